// File: rtl/isa_pkg.sv
// Shared ISA definitions for the 8-bit datapath sequencer: opcodes, ALU selects,
// FSM states, instruction-word field positions and the decoded control bundle.
package isa_pkg;

  // Opcode field values (IR[27:24])
  localparam logic [3:0] OP_LOADI = 4'h0;
  localparam logic [3:0] OP_MOV   = 4'h1;
  localparam logic [3:0] OP_ADD   = 4'h2;
  localparam logic [3:0] OP_SUB   = 4'h3;
  localparam logic [3:0] OP_AND   = 4'h4;
  localparam logic [3:0] OP_OR    = 4'h5;
  localparam logic [3:0] OP_HALT  = 4'hF;

  // ALU function selects
  localparam logic [2:0] ALU_FWD = 3'b000;
  localparam logic [2:0] ALU_ADD = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;

  // Instruction-word field positions and widths
  localparam int IR_SRC1_LSB = 0;
  localparam int IR_IMM_LSB  = 0;
  localparam int IR_SRC2_LSB = 8;
  localparam int IR_DEST_LSB = 16;
  localparam int IR_OPC_LSB  = 24;
  localparam int REG_ADDR_W  = 3;
  localparam int IMM_W       = 8;
  localparam int OPC_W       = 4;

  // Sequencer states
  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_WB,
    S_HALT,
    S_FAULT
  } state_t;

  // Control bundle produced by the decoder for the instruction held in IR
  typedef struct packed {
    logic [2:0] alu_select;
    logic       imm_sel;
    logic       sub_sel;
    logic       writes;
    logic       is_halt;
    logic       is_illegal;
  } decode_t;

endpackage

// File: rtl/instr_decoder.sv
// Purely combinational opcode decoder: turns the IR opcode field into the
// datapath control bundle. Undefined opcodes produce an all-quiet bundle with
// only is_illegal set, so nothing is written for them.
module instr_decoder
  import isa_pkg::*;
(
  input  logic [OPC_W-1:0] i_opcode,
  output decode_t          o_dec
);

  // Map each opcode onto ALU function, operand muxes and write intent
  always_comb begin
    o_dec = '0;
    case (i_opcode)
      OP_LOADI: begin
        o_dec.alu_select = ALU_FWD;
        o_dec.imm_sel    = 1'b1;
        o_dec.writes     = 1'b1;
      end
      OP_MOV: begin
        o_dec.alu_select = ALU_FWD;
        o_dec.writes     = 1'b1;
      end
      OP_ADD: begin
        o_dec.alu_select = ALU_ADD;
        o_dec.writes     = 1'b1;
      end
      OP_SUB: begin
        o_dec.alu_select = ALU_ADD;
        o_dec.sub_sel    = 1'b1;
        o_dec.writes     = 1'b1;
      end
      OP_AND: begin
        o_dec.alu_select = ALU_AND;
        o_dec.writes     = 1'b1;
      end
      OP_OR: begin
        o_dec.alu_select = ALU_OR;
        o_dec.writes     = 1'b1;
      end
      OP_HALT: begin
        o_dec.is_halt = 1'b1;
      end
      default: begin
        o_dec.is_illegal = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/instr_sequencer.sv
// Multi-cycle control sequencer: fetches 32-bit instructions over a req/ack
// handshake, then steps each one through DECODE, EXEC and WB while driving the
// register file, ALU and operand-mux controls. HALT and fetch-timeout FAULT are
// sticky until reset; undefined opcodes pulse illegal and are skipped.
module instr_sequencer
  import isa_pkg::*;
#(
  parameter logic [31:0] RESET_PC      = 32'h0,
  parameter int          PC_STEP       = 4,
  parameter int          FETCH_TIMEOUT = 16,
  // Start value of the retired counter; nonzero only to exercise its wrap point
  parameter logic [15:0] RETIRED_INIT  = 16'h0
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic                  i_run,
  output logic                  o_imem_req,
  output logic [31:0]           o_imem_addr,
  input  logic                  i_imem_ack,
  input  logic [31:0]           i_imem_rdata,
  output logic [REG_ADDR_W-1:0] o_rf_out1addr,
  output logic [REG_ADDR_W-1:0] o_rf_out2addr,
  output logic [REG_ADDR_W-1:0] o_rf_inaddr,
  output logic                  o_rf_we,
  output logic [2:0]            o_alu_select,
  output logic [IMM_W-1:0]      o_imm_value,
  output logic                  o_imm_sel,
  output logic                  o_sub_sel,
  output logic                  o_halted,
  output logic                  o_fault,
  output logic                  o_illegal,
  output logic [15:0]           o_retired
);

  localparam int                WAIT_W    = $clog2(FETCH_TIMEOUT + 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(FETCH_TIMEOUT - 1);

  state_t            r_state;
  logic [31:0]       r_pc;
  logic [31:0]       r_ir;
  logic [WAIT_W-1:0] r_wait;
  logic [15:0]       r_retired;
  logic              r_imem_req;
  logic              r_rf_we;
  logic              r_halted;
  logic              r_fault;

  decode_t           w_dec;
  logic              w_ctrl_active;
  logic [OPC_W-1:0]  w_opcode;
  logic              w_unused_ir_bits;

  assign w_opcode = r_ir[IR_OPC_LSB +: OPC_W];

  instr_decoder u_decoder (
    .i_opcode (w_opcode),
    .o_dec    (w_dec)
  );

  // Decoded controls are only presented while an instruction is in flight
  assign w_ctrl_active = (r_state == S_DECODE) || (r_state == S_EXEC) || (r_state == S_WB);

  assign o_rf_out1addr = w_ctrl_active ? r_ir[IR_SRC1_LSB +: REG_ADDR_W] : '0;
  assign o_rf_out2addr = w_ctrl_active ? r_ir[IR_SRC2_LSB +: REG_ADDR_W] : '0;
  assign o_rf_inaddr   = w_ctrl_active ? r_ir[IR_DEST_LSB +: REG_ADDR_W] : '0;
  assign o_imm_value   = w_ctrl_active ? r_ir[IR_IMM_LSB +: IMM_W] : '0;
  assign o_alu_select  = w_ctrl_active ? w_dec.alu_select : '0;
  assign o_imm_sel     = w_ctrl_active & w_dec.imm_sel;
  assign o_sub_sel     = w_ctrl_active & w_dec.sub_sel;
  assign o_illegal     = (r_state == S_DECODE) & w_dec.is_illegal;

  assign o_imem_req    = r_imem_req;
  assign o_imem_addr   = r_pc;
  assign o_rf_we       = r_rf_we;
  assign o_halted      = r_halted;
  assign o_fault       = r_fault;
  assign o_retired     = r_retired;

  // Instruction bits outside the defined fields are carried in IR but never used
  assign w_unused_ir_bits = ^{r_ir[31:28], r_ir[23:19], r_ir[15:11]};

  // Main FSM: PC, IR, fetch timeout and retired bookkeeping; reset wins over all
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state    <= S_IDLE;
      r_pc       <= RESET_PC;
      r_ir       <= '0;
      r_wait     <= '0;
      r_retired  <= RETIRED_INIT;
      r_imem_req <= 1'b0;
      r_rf_we    <= 1'b0;
      r_halted   <= 1'b0;
      r_fault    <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (i_run) begin
            r_state    <= S_FETCH;
            r_imem_req <= 1'b1;
            r_wait     <= '0;
          end
        end
        S_FETCH: begin
          if (i_imem_ack) begin
            r_ir       <= i_imem_rdata;
            r_imem_req <= 1'b0;
            r_state    <= S_DECODE;
          end else if (r_wait == WAIT_LAST) begin
            r_imem_req <= 1'b0;
            r_fault    <= 1'b1;
            r_state    <= S_FAULT;
          end else begin
            r_wait <= r_wait + 1'b1;
          end
        end
        S_DECODE: begin
          if (w_dec.is_halt) begin
            r_halted <= 1'b1;
            r_state  <= S_HALT;
          end else begin
            r_state <= S_EXEC;
          end
        end
        S_EXEC: begin
          r_rf_we <= w_dec.writes;
          r_state <= S_WB;
        end
        S_WB: begin
          r_rf_we <= 1'b0;
          r_pc    <= r_pc + 32'(PC_STEP);
          if (!w_dec.is_illegal) begin
            r_retired <= r_retired + 16'd1;
          end
          if (i_run) begin
            r_state    <= S_FETCH;
            r_imem_req <= 1'b1;
            r_wait     <= '0;
          end else begin
            r_state <= S_IDLE;
          end
        end
        S_HALT: begin
          r_state <= S_HALT;
        end
        S_FAULT: begin
          r_state <= S_FAULT;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_instr_sequencer.sv
// Directed self-checking bench for instr_sequencer. A second instance whose
// retired counter starts at 16'hFFFF shares all inputs so the wrap to 0 can be
// observed without retiring 65535 instructions.
module tb_instr_sequencer;

  logic        clock = 1'b0;
  logic        reset;
  logic        run;
  logic        imemAck;
  logic [31:0] imemRdata;

  logic        imemReq;
  logic [31:0] imemAddr;
  logic [2:0]  rfOut1Addr;
  logic [2:0]  rfOut2Addr;
  logic [2:0]  rfInAddr;
  logic        rfWe;
  logic [2:0]  aluSelect;
  logic [7:0]  immValue;
  logic        immSel;
  logic        subSel;
  logic        halted;
  logic        fault;
  logic        illegal;
  logic [15:0] retired;

  logic        unused2Req;
  logic [31:0] unused2Addr;
  logic [2:0]  unused2Out1;
  logic [2:0]  unused2Out2;
  logic [2:0]  unused2In;
  logic        unused2We;
  logic [2:0]  unused2Alu;
  logic [7:0]  unused2Imm;
  logic        unused2ImmSel;
  logic        unused2SubSel;
  logic        unused2Halted;
  logic        unused2Fault;
  logic        unused2Illegal;
  logic [15:0] retiredWrap;

  int testsRun    = 0;
  int testsFailed = 0;

  // Free-running 100 MHz style clock
  always #5 clock = ~clock;

  instr_sequencer dut (
    .i_clk         (clock),
    .i_reset       (reset),
    .i_run         (run),
    .o_imem_req    (imemReq),
    .o_imem_addr   (imemAddr),
    .i_imem_ack    (imemAck),
    .i_imem_rdata  (imemRdata),
    .o_rf_out1addr (rfOut1Addr),
    .o_rf_out2addr (rfOut2Addr),
    .o_rf_inaddr   (rfInAddr),
    .o_rf_we       (rfWe),
    .o_alu_select  (aluSelect),
    .o_imm_value   (immValue),
    .o_imm_sel     (immSel),
    .o_sub_sel     (subSel),
    .o_halted      (halted),
    .o_fault       (fault),
    .o_illegal     (illegal),
    .o_retired     (retired)
  );

  instr_sequencer #(.RETIRED_INIT(16'hFFFF)) dutWrap (
    .i_clk         (clock),
    .i_reset       (reset),
    .i_run         (run),
    .o_imem_req    (unused2Req),
    .o_imem_addr   (unused2Addr),
    .i_imem_ack    (imemAck),
    .i_imem_rdata  (imemRdata),
    .o_rf_out1addr (unused2Out1),
    .o_rf_out2addr (unused2Out2),
    .o_rf_inaddr   (unused2In),
    .o_rf_we       (unused2We),
    .o_alu_select  (unused2Alu),
    .o_imm_value   (unused2Imm),
    .o_imm_sel     (unused2ImmSel),
    .o_sub_sel     (unused2SubSel),
    .o_halted      (unused2Halted),
    .o_fault       (unused2Fault),
    .o_illegal     (unused2Illegal),
    .o_retired     (retiredWrap)
  );

  // Advance one clock and settle just after the rising edge
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic applyStimulus(input logic runIn, input logic ackIn, input logic [31:0] rdataIn);
    run       = runIn;
    imemAck   = ackIn;
    imemRdata = rdataIn;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    testsRun++;
    assert (observed === expected)
    else begin
      testsFailed++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Synchronous reset pulse leaving the DUT in IDLE with inputs quiet
  task automatic doReset();
    reset = 1'b1;
    applyStimulus(1'b0, 1'b0, 32'h0);
    tick();
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    applyStimulus(1'b0, 1'b0, 32'h0);
    tick();
    tick();
    reset = 1'b0;

    // Reset state
    checkOutput("rst_req", imemReq, 1'b0);
    checkOutput("rst_addr", imemAddr, 32'h0);
    checkOutput("rst_retired", retired, 16'h0);
    checkOutput("rst_halted", halted, 1'b0);
    checkOutput("rst_fault", fault, 1'b0);
    checkOutput("rst_we", rfWe, 1'b0);
    checkOutput("rst_wrap_retired", retiredWrap, 16'hFFFF);

    // LOADI r1, 5 with immediate ack
    applyStimulus(1'b1, 1'b0, 32'h0);
    tick();
    checkOutput("ld_fetch_req", imemReq, 1'b1);
    checkOutput("ld_fetch_addr", imemAddr, 32'h0);
    applyStimulus(1'b1, 1'b1, 32'h0001_0005);
    tick();
    applyStimulus(1'b1, 1'b0, 32'h0);
    checkOutput("ld_dec_inaddr", rfInAddr, 3'd1);
    checkOutput("ld_dec_imm", immValue, 8'h05);
    checkOutput("ld_dec_immsel", immSel, 1'b1);
    checkOutput("ld_dec_alu", aluSelect, 3'b000);
    checkOutput("ld_dec_we", rfWe, 1'b0);
    checkOutput("ld_dec_req", imemReq, 1'b0);
    tick();
    checkOutput("ld_exec_we", rfWe, 1'b0);
    tick();
    checkOutput("ld_wb_we", rfWe, 1'b1);
    checkOutput("ld_wb_inaddr", rfInAddr, 3'd1);
    tick();
    checkOutput("ld_next_we", rfWe, 1'b0);
    checkOutput("ld_next_addr", imemAddr, 32'h4);
    checkOutput("ld_next_retired", retired, 16'd1);
    checkOutput("ld_next_immsel", immSel, 1'b0);
    checkOutput("ld_next_req", imemReq, 1'b1);
    checkOutput("wrap_retired", retiredWrap, 16'h0);

    // OR in flight, reset asserted in EXEC together with a stray ack
    applyStimulus(1'b1, 1'b1, 32'h0503_0201);
    tick();
    applyStimulus(1'b1, 1'b0, 32'h0);
    tick();
    checkOutput("or_exec_alu", aluSelect, 3'b011);
    checkOutput("or_exec_src1", rfOut1Addr, 3'd1);
    checkOutput("or_exec_src2", rfOut2Addr, 3'd2);
    checkOutput("or_exec_dest", rfInAddr, 3'd3);
    reset = 1'b1;
    applyStimulus(1'b1, 1'b1, 32'h0000_0000);
    tick();
    reset = 1'b0;
    applyStimulus(1'b0, 1'b0, 32'h0);
    checkOutput("rstx_req", imemReq, 1'b0);
    checkOutput("rstx_addr", imemAddr, 32'h0);
    checkOutput("rstx_retired", retired, 16'h0);
    checkOutput("rstx_alu", aluSelect, 3'b000);
    checkOutput("rstx_we", rfWe, 1'b0);
    checkOutput("rstx_dest", rfInAddr, 3'd0);
    checkOutput("rstx_wrap_retired", retiredWrap, 16'hFFFF);

    // ADD, SUB, HALT from PC 0
    applyStimulus(1'b1, 1'b0, 32'h0);
    tick();
    applyStimulus(1'b1, 1'b1, 32'h0202_0101);
    tick();
    applyStimulus(1'b1, 1'b0, 32'h0);
    checkOutput("add_alu", aluSelect, 3'b001);
    checkOutput("add_sub", subSel, 1'b0);
    checkOutput("add_src1", rfOut1Addr, 3'd1);
    checkOutput("add_src2", rfOut2Addr, 3'd1);
    checkOutput("add_dest", rfInAddr, 3'd2);
    tick();
    tick();
    checkOutput("add_wb_we", rfWe, 1'b1);
    tick();
    checkOutput("add_next_addr", imemAddr, 32'h4);
    applyStimulus(1'b1, 1'b1, 32'h0303_0201);
    tick();
    applyStimulus(1'b1, 1'b0, 32'h0);
    checkOutput("sub_alu", aluSelect, 3'b001);
    checkOutput("sub_sub", subSel, 1'b1);
    checkOutput("sub_src2", rfOut2Addr, 3'd2);
    tick();
    checkOutput("sub_exec_sub", subSel, 1'b1);
    tick();
    tick();
    checkOutput("sub_next_addr", imemAddr, 32'h8);
    checkOutput("sub_next_retired", retired, 16'd2);
    applyStimulus(1'b1, 1'b1, 32'h0F00_0000);
    tick();
    applyStimulus(1'b1, 1'b0, 32'h0);
    checkOutput("halt_dec_halted", halted, 1'b0);
    tick();
    checkOutput("halt_halted", halted, 1'b1);
    checkOutput("halt_addr", imemAddr, 32'h8);
    checkOutput("halt_req", imemReq, 1'b0);
    checkOutput("halt_retired", retired, 16'd2);
    tick();
    tick();
    checkOutput("halt_stay_req", imemReq, 1'b0);
    checkOutput("halt_stay_halted", halted, 1'b1);

    // Ack delayed by 3 cycles
    doReset();
    checkOutput("halt_cleared", halted, 1'b0);
    applyStimulus(1'b1, 1'b0, 32'h0);
    tick();
    for (int i = 0; i < 3; i++) begin
      checkOutput("dly_req", imemReq, 1'b1);
      checkOutput("dly_addr", imemAddr, 32'h0);
      tick();
    end
    checkOutput("dly_last_req", imemReq, 1'b1);
    applyStimulus(1'b1, 1'b1, 32'h0002_0007);
    tick();
    applyStimulus(1'b1, 1'b0, 32'h0);
    checkOutput("dly_dec_dest", rfInAddr, 3'd2);
    checkOutput("dly_dec_imm", immValue, 8'h07);
    checkOutput("dly_dec_req", imemReq, 1'b0);
    tick();
    tick();
    tick();
    checkOutput("dly_next_addr", imemAddr, 32'h4);

    // Ack in the last allowed FETCH cycle is accepted
    for (int i = 0; i < 15; i++) begin
      tick();
    end
    checkOutput("bnd_req", imemReq, 1'b1);
    checkOutput("bnd_fault", fault, 1'b0);
    applyStimulus(1'b1, 1'b1, 32'h0103_0002);
    tick();
    applyStimulus(1'b1, 1'b0, 32'h0);
    checkOutput("bnd_dec_fault", fault, 1'b0);
    checkOutput("bnd_dec_src1", rfOut1Addr, 3'd2);
    checkOutput("bnd_dec_dest", rfInAddr, 3'd3);
    tick();
    tick();
    tick();
    checkOutput("bnd_next_addr", imemAddr, 32'h8);
    checkOutput("bnd_next_retired", retired, 16'd2);

    // Ack never arrives: FAULT after 16 FETCH cycles
    for (int i = 0; i < 15; i++) begin
      tick();
    end
    checkOutput("to_req_before", imemReq, 1'b1);
    checkOutput("to_fault_before", fault, 1'b0);
    tick();
    checkOutput("to_fault", fault, 1'b1);
    checkOutput("to_req", imemReq, 1'b0);
    checkOutput("to_addr", imemAddr, 32'h8);
    tick();
    checkOutput("to_fault_stay", fault, 1'b1);

    // Illegal opcode 0111
    doReset();
    checkOutput("fault_cleared", fault, 1'b0);
    applyStimulus(1'b1, 1'b0, 32'h0);
    tick();
    applyStimulus(1'b1, 1'b1, 32'h0701_0203);
    tick();
    applyStimulus(1'b1, 1'b0, 32'h0);
    checkOutput("ill_dec_pulse", illegal, 1'b1);
    checkOutput("ill_dec_we", rfWe, 1'b0);
    tick();
    checkOutput("ill_exec_pulse", illegal, 1'b0);
    tick();
    checkOutput("ill_wb_we", rfWe, 1'b0);
    tick();
    checkOutput("ill_next_addr", imemAddr, 32'h4);
    checkOutput("ill_next_retired", retired, 16'h0);
    checkOutput("ill_wrap_retired", retiredWrap, 16'hFFFF);

    // run dropped during DECODE: AND completes, then IDLE
    doReset();
    applyStimulus(1'b1, 1'b0, 32'h0);
    tick();
    applyStimulus(1'b1, 1'b1, 32'h0401_0302);
    tick();
    applyStimulus(1'b0, 1'b0, 32'h0);
    checkOutput("rd_dec_alu", aluSelect, 3'b010);
    tick();
    tick();
    checkOutput("rd_wb_we", rfWe, 1'b1);
    tick();
    checkOutput("rd_idle_req", imemReq, 1'b0);
    checkOutput("rd_idle_addr", imemAddr, 32'h4);
    checkOutput("rd_idle_retired", retired, 16'd1);
    checkOutput("rd_idle_alu", aluSelect, 3'b000);

    // Ack outside FETCH is ignored
    applyStimulus(1'b0, 1'b1, 32'h0007_0009);
    tick();
    applyStimulus(1'b0, 1'b0, 32'h0);
    checkOutput("stray_req", imemReq, 1'b0);
    checkOutput("stray_dest", rfInAddr, 3'd0);
    checkOutput("stray_illegal", illegal, 1'b0);
    tick();
    checkOutput("stray_stay_req", imemReq, 1'b0);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
